// File: rtl/wb_commit_arbiter_pkg.sv
// Shared regfile bus definitions and small helpers for the writeback commit arbiter.
// The optional starve guard is enabled by defining YSYX22040228_WB_STARVE_GUARD_EN.
package wb_commit_arbiter_pkg;
   localparam int              REGBUS     = 64;
   localparam int              REGADDRBUS = 5;
   localparam logic            WENABLE    = 1'b1;
   localparam logic [63:0]     ZEROWORD   = 64'h0;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_EXE  = 2'd1,
      GNT_LSU  = 2'd2
   } gnt_e;

   // Occupancy counter must represent 0..DEPTH inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/wb_commit_arbiter_fifo.sv
// Per-source result FIFO (wb_fifo): DEPTH entries of {rd, data}, with per-entry valid/rd
// exposed so the top can match pending writes against every buffered result.
module wb_fifo
   import wb_commit_arbiter_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_push,
   input  logic [ADDR_W-1:0]             i_rd,
   input  logic [DATA_W-1:0]             i_data,
   input  logic                          i_pop,
   output logic                          o_ready,
   output logic                          o_empty,
   output logic [ADDR_W-1:0]             o_head_rd,
   output logic [DATA_W-1:0]             o_head_data,
   output logic [DEPTH-1:0]              o_vld,
   output logic [DEPTH-1:0][ADDR_W-1:0]  o_rd
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DEPTH-1:0][ADDR_W-1:0] r_rd;
   logic [DEPTH-1:0][DATA_W-1:0] r_data;
   logic [DEPTH-1:0]             r_vld;
   logic [PW-1:0]                r_wptr;
   logic [PW-1:0]                r_rptr;
   logic [CW-1:0]                r_cnt;

   // Ready comes from the registered count only: a full FIFO stays closed even while popping.
   assign o_ready     = !rst && (r_cnt < CW'(DEPTH));
   assign o_empty     = (r_cnt == '0);
   assign o_head_rd   = r_rd[r_rptr];
   assign o_head_data = r_data[r_rptr];
   assign o_vld       = r_vld;
   assign o_rd        = r_rd;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_vld  <= '0;
      end else begin
         if (i_push) begin
            r_vld[r_wptr] <= 1'b1;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (i_pop) begin
            r_vld[r_rptr] <= 1'b0;
            r_rptr        <= r_rptr + 1'b1;
         end
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !rst) begin
         r_rd[r_wptr]   <= i_rd;
         r_data[r_wptr] <= i_data;
      end
   end
endmodule

// File: rtl/wb_commit_arbiter.sv
// Writeback commit arbiter: buffers exe/lsu results, grants one regfile write per cycle
// (lsu first), and answers pending-write hazard queries. Option: YSYX22040228_WB_STARVE_GUARD_EN.
module wb_commit_arbiter
   import wb_commit_arbiter_pkg::*;
#(
   parameter int DATA_W = REGBUS,
   parameter int ADDR_W = REGADDRBUS,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exe_valid,
   output logic              exe_ready,
   input  logic [ADDR_W-1:0] exe_rd,
   input  logic [DATA_W-1:0] exe_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] pend_addr,
   output logic              pend_hit
);
   logic                         w_exe_empty, w_lsu_empty;
   logic [ADDR_W-1:0]            w_exe_hrd, w_lsu_hrd;
   logic [DATA_W-1:0]            w_exe_hdata, w_lsu_hdata;
   logic [DEPTH-1:0]             w_exe_vld, w_lsu_vld;
   logic [DEPTH-1:0][ADDR_W-1:0] w_exe_rdv, w_lsu_rdv;
   gnt_e                         w_gnt;
   logic                         w_hit;

   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;

   wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_exe_fifo (
      .clk(clk), .rst(rst),
      .i_push(exe_valid && exe_ready), .i_rd(exe_rd), .i_data(exe_data),
      .i_pop(w_gnt == GNT_EXE),
      .o_ready(exe_ready), .o_empty(w_exe_empty),
      .o_head_rd(w_exe_hrd), .o_head_data(w_exe_hdata),
      .o_vld(w_exe_vld), .o_rd(w_exe_rdv)
   );

   wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lsu_fifo (
      .clk(clk), .rst(rst),
      .i_push(lsu_valid && lsu_ready), .i_rd(lsu_rd), .i_data(lsu_data),
      .i_pop(w_gnt == GNT_LSU),
      .o_ready(lsu_ready), .o_empty(w_lsu_empty),
      .o_head_rd(w_lsu_hrd), .o_head_data(w_lsu_hdata),
      .o_vld(w_lsu_vld), .o_rd(w_lsu_rdv)
   );

`ifdef YSYX22040228_WB_STARVE_GUARD_EN
   logic [1:0] r_starve_cnt;
   logic       r_force_exe;

   // Four lsu grants in a row with exe waiting earn exe the next slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= 2'd0;
         r_force_exe  <= 1'b0;
      end else if (w_exe_empty || w_gnt == GNT_EXE) begin
         r_starve_cnt <= 2'd0;
         r_force_exe  <= 1'b0;
      end else if (w_gnt == GNT_LSU) begin
         if (r_starve_cnt == 2'd3) begin
            r_starve_cnt <= 2'd0;
            r_force_exe  <= 1'b1;
         end else begin
            r_starve_cnt <= r_starve_cnt + 2'd1;
         end
      end
   end

   always_comb begin
      w_gnt = GNT_NONE;
      if (r_force_exe && !w_exe_empty) w_gnt = GNT_EXE;
      else if (!w_lsu_empty)           w_gnt = GNT_LSU;
      else if (!w_exe_empty)           w_gnt = GNT_EXE;
   end
`else
   always_comb begin
      w_gnt = GNT_NONE;
      if (!w_lsu_empty)      w_gnt = GNT_LSU;
      else if (!w_exe_empty) w_gnt = GNT_EXE;
   end
`endif

   // x0 results still consume their slot but never assert the write enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we    <= ~WENABLE;
         r_waddr <= '0;
         r_wdata <= DATA_W'(ZEROWORD);
      end else begin
         r_we <= ~WENABLE;
         if (w_gnt == GNT_LSU) begin
            r_we    <= (w_lsu_hrd != '0) ? WENABLE : ~WENABLE;
            r_waddr <= w_lsu_hrd;
            r_wdata <= w_lsu_hdata;
         end else if (w_gnt == GNT_EXE) begin
            r_we    <= (w_exe_hrd != '0) ? WENABLE : ~WENABLE;
            r_waddr <= w_exe_hrd;
            r_wdata <= w_exe_hdata;
         end
      end
   end

   assign we    = r_we;
   assign waddr = r_waddr;
   assign wdata = r_wdata;

   always_comb begin
      w_hit = r_we && (r_waddr == pend_addr);
      for (int i = 0; i < DEPTH; i++) begin
         if (w_exe_vld[i] && w_exe_rdv[i] == pend_addr) w_hit = 1'b1;
         if (w_lsu_vld[i] && w_lsu_rdv[i] == pend_addr) w_hit = 1'b1;
      end
   end

   assign pend_hit = (pend_addr != '0) && w_hit;
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Self-checking bench for wb_commit_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_wb_commit_arbiter;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 2;
`ifdef YSYX22040228_WB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              exe_valid, exe_ready, lsu_valid, lsu_ready;
   logic [ADDR_W-1:0] exe_rd, lsu_rd, waddr, pend_addr;
   logic [DATA_W-1:0] exe_data, lsu_data, wdata;
   logic              we, pend_hit;

   wb_commit_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_rd(exe_rd), .exe_data(exe_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .we(we), .waddr(waddr), .wdata(wdata),
      .pend_addr(pend_addr), .pend_hit(pend_hit)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t              qe[$];
   ent_t              ql[$];
   logic              m_we;
   logic [ADDR_W-1:0] m_waddr;
   logic [DATA_W-1:0] m_wdata;
   int                m_cnt;
   int                nvec = 0;
   int                nmis = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_pend();
      bit h;
      h = m_we && (m_waddr == pend_addr);
      foreach (qe[i]) if (qe[i].rd == pend_addr) h = 1'b1;
      foreach (ql[i]) if (ql[i].rd == pend_addr) h = 1'b1;
      return (pend_addr != 0) && h;
   endfunction

   // One clock edge of the specified behaviour, applied to the queues.
   task automatic model_edge();
      bit   ea, la, ge, gl;
      ent_t e;
      if (rst) begin
         qe.delete(); ql.delete();
         m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
         return;
      end
      ea = exe_valid && (qe.size() < DEPTH);
      la = lsu_valid && (ql.size() < DEPTH);
      ge = 1'b0; gl = 1'b0;
      if (GUARD && m_cnt >= 4 && qe.size() > 0) ge = 1'b1;
      else if (ql.size() > 0)                   gl = 1'b1;
      else if (qe.size() > 0)                   ge = 1'b1;
      if (GUARD) begin
         if (qe.size() == 0 || ge) m_cnt = 0;
         else if (gl)              m_cnt++;
      end
      m_we = 1'b0;
      if (ge) e = qe.pop_front();
      if (gl) e = ql.pop_front();
      if (ge || gl) begin
         m_we = (e.rd != 0); m_waddr = e.rd; m_wdata = e.data;
      end
      if (ea) qe.push_back('{rd: exe_rd, data: exe_data});
      if (la) ql.push_back('{rd: lsu_rd, data: lsu_data});
   endtask

   // Called just after a negedge with inputs already driven.
   task automatic tick();
      #1;
      chk("exe_ready", exe_ready, (!rst && qe.size() < DEPTH));
      chk("lsu_ready", lsu_ready, (!rst && ql.size() < DEPTH));
      chk("pend_hit",  pend_hit,  m_pend());
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("we",    we,    m_we);
      chk("waddr", waddr, m_waddr);
      chk("wdata", wdata, m_wdata);
      chk("no_x0_write", (we && waddr == 0), 1'b0);
   endtask

   initial begin
      int hit_at, nwr;
      rst = 1'b1; exe_valid = 1'b1; exe_rd = 5'd1; exe_data = 64'h1234;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0; pend_addr = '0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;

      // Reset held with exe_valid high: nothing accepted
      repeat (3) tick();
      chk("rst_we", we, 1'b0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      rst = 1'b0; exe_valid = 1'b0;
      #1;
      chk("ready_after_rst", exe_ready, 1'b1);
      tick();

      // Single exe result: visible two cycles after acceptance
      exe_valid = 1'b1; exe_rd = 5'd5; exe_data = 64'hDEAD;
      tick();
      chk("single_n1_we", we, 1'b0);
      exe_valid = 1'b0;
      tick();
      chk("single_we", we, 1'b1);
      chk("single_waddr", waddr, 5);
      chk("single_wdata", wdata, 64'hDEAD);
      tick();
      chk("single_after_we", we, 1'b0);

      // Collision: lsu commits first
      exe_valid = 1'b1; exe_rd = 5'd3; exe_data = 64'h11;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h22;
      tick();
      exe_valid = 1'b0; lsu_valid = 1'b0;
      tick();
      chk("coll1_waddr", waddr, 4);
      chk("coll1_wdata", wdata, 64'h22);
      tick();
      chk("coll2_we", we, 1'b1);
      chk("coll2_waddr", waddr, 3);
      chk("coll2_wdata", wdata, 64'h11);
      tick();

      // Pending-write query: buffered, in flight, then gone
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h77; pend_addr = 5'd7;
      tick();
      chk("pend_buffered", pend_hit, 1'b1);
      lsu_valid = 1'b0;
      tick();
      chk("pend_inflight", pend_hit, 1'b1);
      tick();
      chk("pend_committed", pend_hit, 1'b0);
      pend_addr = '0;
      #1;
      chk("pend_x0", pend_hit, 1'b0);
      tick();

      // x0 results with the sink held by continuous lsu traffic
      exe_valid = 1'b1; exe_rd = 5'd0; exe_data = 64'hAB;
      for (int i = 0; i < 6; i++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(8 + i); lsu_data = 64'(i);
         if (i == 2) begin
            #1;
            chk("x0_backpressure", exe_ready, 1'b0);
         end
         tick();
      end
      exe_valid = 1'b0; lsu_valid = 1'b0;
      repeat (6) tick();

      // Starvation: exe holds one entry against continuous lsu results
      exe_valid = 1'b1; exe_rd = 5'd9; exe_data = 64'h99;
      hit_at = 0; nwr = 0;
      for (int i = 0; i < 10; i++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(16 + i); lsu_data = 64'(100 + i);
         tick();
         exe_valid = 1'b0;
         if (i > 0) nwr++;
         if (we && waddr == 5'd9 && hit_at == 0) hit_at = nwr;
      end
      chk("starve_exe_slot", hit_at, GUARD ? 5 : 0);
      lsu_valid = 1'b0;
      repeat (6) tick();

      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         exe_valid = $urandom_range(0, 1);
         lsu_valid = ($urandom_range(0, 2) == 0);
         exe_rd    = 5'($urandom_range(0, 7));
         lsu_rd    = 5'($urandom_range(0, 7));
         exe_data  = {$urandom, $urandom};
         lsu_data  = {$urandom, $urandom};
         pend_addr = 5'($urandom_range(0, 7));
         tick();
      end
      rst = 1'b0; exe_valid = 1'b0; lsu_valid = 1'b0;
      repeat (6) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/wb_commit_arbiter.md
# wb_commit_arbiter

Writeback stage that drives the single regfile write port (we, waddr, wdata). It accepts results from two producers, the execute pipe (exe) and the load/store unit (lsu), through valid/ready channels. Each result is buffered in a per-source FIFO, one write per cycle is granted by fixed priority, and the write is issued from registered outputs. A combinational pending-write query lets decode detect RAW hazards on results not yet committed.

## Interface
Parameters:
- DATA_W, 64, result width; equals regfile data width.
- ADDR_W, 5, register index width.
- DEPTH, 2, entries per source FIFO; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- exe_valid  in  1  exe result valid.
- exe_ready  out  1  exe FIFO can accept.
- exe_rd  in  ADDR_W  exe destination register.
- exe_data  in  DATA_W  exe result.
- lsu_valid  in  1  load result valid.
- lsu_ready  out  1  lsu FIFO can accept.
- lsu_rd  in  ADDR_W  load destination register.
- lsu_data  in  DATA_W  load result.
- we  out  1  regfile write enable (registered).
- waddr  out  ADDR_W  regfile write address (registered).
- wdata  out  DATA_W  regfile write data (registered).
- pend_addr  in  ADDR_W  hazard query address.
- pend_hit  out  1  a write to pend_addr is buffered or in flight.

## Operation
- Accept on valid && ready, per source independently; both sources may be accepted in the same cycle.
- ready = FIFO count < DEPTH, computed from the registered count only. A full FIFO holds ready low even in a cycle with a pop; there is no pass-through.
- Arbitration among non-empty FIFO heads: lsu wins over exe. At most one pop per cycle.
- Popped entry loads the output register. we=1 only if rd != 0. An rd==0 entry is still popped (consumes the slot) with we=0.
- No pop in a cycle: we=0 next cycle; waddr/wdata hold their last values.
- Ordering across sources: upstream issue logic stalls any instruction whose rd matches an outstanding load, so cross-source WAW never occurs. Within a source, FIFO order is preserved.
- pend_hit = (pend_addr != 0) && (pend_addr matches any valid entry in either FIFO, or matches waddr while we=1).
- Pointers wrap modulo DEPTH; count is ADDR-independent, width clog2(DEPTH)+1.

## Timing
- Reset values: we=0, waddr=0, wdata=0, both FIFOs empty, exe_ready=lsu_ready=0 during rst, then 1 from the first cycle after rst deasserts.
- Latency: accepted at edge N → head available in cycle N+1 → we high in cycle N+2 if granted at N+1.
- Throughput: 1 write/cycle aggregate; exe can starve while lsu stays non-empty (see Configuration).
- rst mid-operation: all buffered entries are discarded and we=0 on the next cycle. Accepted-but-uncommitted results are lost by design; the pipeline is flushed alongside.
- pend_hit is combinational from the current registered state; it does not reflect same-cycle inputs.

## Configuration
- YSYX22040228_WB_STARVE_GUARD_EN defined: a 2-bit counter of consecutive lsu grants made while exe is non-empty. After 4 such grants, the next cycle grants exe if exe is non-empty, then the counter clears. The counter also clears on any exe grant or when exe is empty.
- Not defined: pure fixed priority lsu > exe, no counter.

## Structure
- Widths (REGBUS, REGADDRBUS), WENABLE, and ZEROWORD come from the shared defines header; no local redefinition.
- One sub-module, wb_fifo (DEPTH entries of {rd, data}, push/pop, count, per-entry valid/rd exposed for the pend match), instantiated twice.
- Arbiter, output register, starve counter, and pend compare live in the top.

## Test plan
- Reset: hold rst 3 cycles with exe_valid=1 → we=0, waddr=0, wdata=0, no entry accepted; first cycle after release exe_ready=1.
- Single exe: exe rd=5 data=0xDEAD accepted at edge N → we=1, waddr=5, wdata=0xDEAD in cycle N+2 only.
- Collision: exe rd=3 data=0x11 and lsu rd=4 data=0x22 in the same cycle → writes x4=0x22 then x3=0x11 on consecutive cycles.
- x0 and backpressure: 3 exe results with rd=0, DEPTH=2, sink stalled by continuous lsu traffic → exe_ready=0 after 2 accepts, and no we=1 with waddr=0 ever.
- pend_hit: lsu rd=7 buffered, pend_addr=7 → 1; after its commit cycle → 0; pend_addr=0 → always 0.
- Starve guard (macro on): lsu valid every cycle with distinct rd, exe holding 1 entry → exe commits on the 5th write; macro off → exe never commits while lsu is non-empty.
